mmio_uart_tx: RTL

Memory-mapped UART transmitter on the processor's data bus, downstream of the core's store path. It decodes `memwrite`/`dataadr`/`writedata` in parallel with the data memory and accepts bytes into an 8-entry FIFO. It serialises them 8N1 on `txd` and returns a status word to the core's load mux. It occupies a 16-byte window above the data-memory range.

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/mmio_uart_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions and the TX state encoding live here.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam logic [3:0] UART_DATA_OFS   = 4'h0;
   localparam logic [3:0] UART_STATUS_OFS = 4'h4;
   localparam logic [3:0] UART_CTRL_OFS   = 4'h8;
   localparam logic [3:0] UART_RSVD_OFS   = 4'hC;

   localparam int unsigned STAT_BUSY_BIT  = 0;
   localparam int unsigned STAT_FULL_BIT  = 1;
   localparam int unsigned STAT_EMPTY_BIT = 2;
   localparam int unsigned STAT_OVF_BIT   = 3;
   localparam int unsigned STAT_CNT_LSB   = 4;
   localparam int unsigned STAT_CNT_W     = 4;

   localparam int unsigned UART_DATA_BITS = 8;
   localparam int unsigned UART_BIT_IDX_W = 3;

   // Assemble the STATUS word; unused bits read as zero.
   function automatic logic [31:0] pack_status(
      input logic                  busy,
      input logic                  full,
      input logic                  empty,
      input logic                  ovf,
      input logic [STAT_CNT_W-1:0] cnt
   );
      logic [31:0] w;
      w                                     = '0;
      w[STAT_BUSY_BIT]                      = busy;
      w[STAT_FULL_BIT]                      = full;
      w[STAT_EMPTY_BIT]                     = empty;
      w[STAT_OVF_BIT]                       = ovf;
      w[STAT_CNT_LSB +: STAT_CNT_W]         = cnt;
      return w;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = cnt_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage carries no reset; when full, the write slot equals the slot being popped.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: address decode, byte FIFO, sticky
// overflow flag, combinational STATUS read mux and the serialising FSM.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic        sel,
   output logic [31:0] readdata,
   output logic        txd
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BIT_W  = UART_BIT_IDX_W;

   uart_state_t                     state_q, state_d;
   logic        [BAUD_W-1:0]        baud_q, baud_d;
   logic        [BIT_W-1:0]         bit_q, bit_d;
   logic        [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                            txd_q, txd_d;
   logic                            ovf_q, ovf_d;

   logic                            wr_data, wr_ctrl, ovf_event;
   logic                            baud_last;
   logic                            fifo_pop;
   logic        [UART_DATA_BITS-1:0] fifo_rdata;
   logic        [CNT_W-1:0]         fifo_count;
   logic                            fifo_full, fifo_empty;
   logic        [31:0]              status_word;
   logic                            unused_bits;

   // Address decode runs in parallel with the data memory.
   assign sel     = (dataadr[31:4] == BASE_ADDR[31:4]);
   assign wr_data = memwrite && sel && (dataadr[3:2] == UART_DATA_OFS[3:2]);
   assign wr_ctrl = memwrite && sel && (dataadr[3:2] == UART_CTRL_OFS[3:2]);

   assign unused_bits = ^{writedata[31:UART_DATA_BITS], dataadr[1:0]};

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (wr_data),
      .pop   (fifo_pop),
      .wdata (writedata[UART_DATA_BITS-1:0]),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A dropped push sets ovf; setting beats a same-cycle CTRL clear.
   assign ovf_event = wr_data && fifo_full && !fifo_pop;

   always_comb begin
      ovf_d = ovf_q;
      if (wr_ctrl) begin
         ovf_d = 1'b0;
      end
      if (ovf_event) begin
         ovf_d = 1'b1;
      end
   end

   assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

   // TX next-state logic; the baud counter clears on every state entry.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      txd_d    = 1'b1;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               baud_d   = '0;
               state_d  = START;
            end
         end
         START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_last) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         ovf_q   <= ovf_d;
      end
   end

   assign txd = txd_q;

   assign status_word = pack_status(
      (state_q != IDLE),
      fifo_full,
      fifo_empty,
      ovf_q,
      STAT_CNT_W'(fifo_count)
   );

   // Single-cycle load path: only STATUS returns non-zero data.
   always_comb begin
      readdata = '0;
      if (sel && (dataadr[3:2] == UART_STATUS_OFS[3:2])) begin
         readdata = status_word;
      end
   end

endmodule
